// File: rtl/fft_overlap_framer.sv
// fft_overlap_framer
//   Overlapping-frame buffer between the decimated sample stream and the FFT
//   core. Incoming samples are written into a 2N-entry circular RAM. Frames of
//   N = 2^FFT_LENGTH_LOG2 consecutive samples are streamed out, and each frame
//   starts a runtime-programmable hop after the previous one.
//
//   Handshake: an output beat transfers on a rising edge where
//   o_valid & i_ready. While o_valid=1 and i_ready=0, o_data/o_last hold.
//   The input side has no ready: a sample is accepted whenever i_valid=1 and
//   the buffer has room. Otherwise it is dropped and o_overflow is set.
//
// Ports
//   i_clk, i_resetn    clock (rising edge), asynchronous active-low reset
//   i_data, i_valid    input sample stream (no back-pressure)
//   i_hop              new samples per frame (0 or >N treated as N)
//   o_data, o_valid    output frame stream
//   i_ready            output back-pressure
//   o_last             high on the final beat (N-1) of each frame
//   o_frame_count      completed frames, wraps
//   o_overflow         sticky dropped-sample flag
//   i_clear_overflow   synchronous clear of o_overflow (a new drop wins)
module fft_overlap_framer #(
    parameter int DATA_WIDTH      = 16,
    parameter int FFT_LENGTH_LOG2 = 11,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    input  logic [FFT_LENGTH_LOG2:0]   i_hop,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_count,
    output logic                       o_overflow,
    input  logic                       i_clear_overflow
);
    localparam int LW = FFT_LENGTH_LOG2;
    localparam int PW = FFT_LENGTH_LOG2 + 1;
    localparam int OW = FFT_LENGTH_LOG2 + 2;
    localparam logic [PW-1:0] N_P    = PW'(1) << LW;
    localparam logic [OW-1:0] N_O    = OW'(1) << LW;
    localparam logic [OW-1:0] TWON_O = OW'(1) << PW;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              fs_ptr_q, fs_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]              occ_q, occ_d;
    logic [PW-1:0]              hop_q, hop_d;
    logic [LW-1:0]              beat_q, beat_d;
    logic [PW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       ovf_q, ovf_d;
    logic                       skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0]      skid_data_q, skid_data_d;
    logic                       rvld_q, rvld_d;
    logic [DATA_WIDTH-1:0]      rdata_q;

    logic pop, last_beat, frame_done, start_frame, rd_en, wr_en;
    logic skid_keep, rd_keep;

    logic [DATA_WIDTH-1:0] mem [0:(1<<PW)-1];

    // Simple dual-port RAM; the registered read port is the first output stage.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_q] <= i_data;
        if (rd_en) rdata_q <= mem[rd_ptr_q];
    end

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_frame) state_d = S_PRIME;
            S_PRIME:  state_d = S_STREAM;
            S_STREAM: if (frame_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        o_valid     = skid_vld_q | rvld_q;
        pop         = o_valid & i_ready;
        last_beat   = (beat_q == {LW{1'b1}});
        o_last      = o_valid & last_beat & (state_q == S_STREAM);
        frame_done  = (state_q == S_STREAM) & pop & last_beat;
        start_frame = (state_q == S_IDLE) & (occ_q >= N_O);
        // A read is allowed unless both output entries stay occupied this cycle.
        rd_en       = ((state_q == S_PRIME) || (state_q == S_STREAM))
                      && (rd_cnt_q < N_P) && !(skid_vld_q && rvld_q && !pop);
        wr_en       = i_valid & (occ_q < TWON_O);
        o_data      = skid_vld_q ? skid_data_q : (rvld_q ? rdata_q : '0);
        o_frame_count = frame_cnt_q;
        o_overflow    = ovf_q;
    end

    // Datapath next values
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(wr_en);
        occ_d       = occ_q + OW'(wr_en) - (frame_done ? OW'(hop_q) : '0);
        fs_ptr_d    = frame_done ? fs_ptr_q + hop_q : fs_ptr_q;
        hop_d       = hop_q;
        if (start_frame) hop_d = ((i_hop == '0) || (i_hop > N_P)) ? N_P : i_hop;
        rd_ptr_d    = start_frame ? fs_ptr_q : rd_ptr_q + PW'(rd_en);
        rd_cnt_d    = start_frame ? '0 : rd_cnt_q + PW'(rd_en);
        beat_d      = start_frame ? '0 : beat_q + LW'(pop);
        frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(frame_done);

        ovf_d = ovf_q;
        if (i_valid && !wr_en)  ovf_d = 1'b1;
        else if (i_clear_overflow) ovf_d = 1'b0;

        // Skid: the skid register always holds the older entry. A pop takes
        // the skid entry first. A new read pushes unconsumed RAM data into skid.
        skid_keep   = skid_vld_q & ~pop;
        rd_keep     = rvld_q & ~(pop & ~skid_vld_q);
        skid_vld_d  = skid_keep;
        skid_data_d = skid_data_q;
        rvld_d      = rd_keep;
        if (rd_en) begin
            rvld_d = 1'b1;
            if (rd_keep) begin
                skid_vld_d  = 1'b1;
                skid_data_d = rdata_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr_q    <= '0;
            fs_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            hop_q       <= '0;
            beat_q      <= '0;
            rd_cnt_q    <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            rvld_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fs_ptr_q    <= fs_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            hop_q       <= hop_d;
            beat_q      <= beat_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            rvld_q      <= rvld_d;
        end
    end
endmodule

// File: tb/tb_fft_overlap_framer.sv
// Testbench for fft_overlap_framer with N=8 (FFT_LENGTH_LOG2=3).
// A table of ramp scenarios gives the hop, the sample count, the ready
// pattern and the expected frame starts. A negedge monitor compares every
// output beat against the expected queue. A hand-written sequence covers
// reset asserted mid-frame.
module tb_fft_overlap_framer;
    localparam int DW = 16;
    localparam int L  = 3;
    localparam int N  = 8;
    localparam int FW = 16;

    logic          clk = 0;
    logic          i_resetn = 0;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 0;
    logic [L:0]    i_hop = 4'd4;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1;
    logic          o_last;
    logic [FW-1:0] o_frame_count;
    logic          o_overflow;
    logic          i_clear_overflow = 0;

    fft_overlap_framer #(.DATA_WIDTH(DW), .FFT_LENGTH_LOG2(L), .FRAME_CNT_WIDTH(FW)) dut (
        .i_clk(clk), .i_resetn(i_resetn), .i_data(i_data), .i_valid(i_valid),
        .i_hop(i_hop), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_frame_count(o_frame_count), .o_overflow(o_overflow),
        .i_clear_overflow(i_clear_overflow)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic          mon_en = 0;
    int            mon_beat = 0;
    int            frames_done = 0;
    logic          first_seen = 0;
    int            first_cyc = 0;
    logic          stall_pend = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] exp_v;

    always @(negedge clk) begin
        if (mon_en && i_resetn) begin
            if (stall_pend) begin
                check("stall_valid", int'(o_valid), 1);
                check("stall_data", int'(o_data), int'(prev_data));
                check("stall_last", int'(o_last), int'(prev_last));
            end
            if (o_valid && !first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", int'(o_data), -1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("data", int'(o_data), int'(exp_v));
                    check("last", int'(o_last), (mon_beat == N - 1) ? 1 : 0);
                    check("frame_count", int'(o_frame_count), frames_done);
                    if (mon_beat == N - 1) begin
                        mon_beat = 0;
                        frames_done++;
                    end else begin
                        mon_beat++;
                    end
                end
            end
            stall_pend = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [L:0] hop_a;   // hop at start
        logic [L:0] hop_b;   // hop applied once frame0 is streaming
        int nsamp;
        int rmode;           // 0: ready=1, 1: 1,0,0,1 pattern, 2: 0 until input done
        int nframes;
        int s0, s1, s2;      // expected frame starts (relative to ramp base)
        int ovf;
    } case_t;

    case_t cases[7];
    int    wr7_cyc;

    task automatic do_reset();
        i_resetn = 0;
        i_valid  = 0;
        repeat (2) @(posedge clk);
        #1 i_resetn = 1;
    endtask

    task automatic run_case(input case_t c, input int base, input logic rst, input string tag);
        int idx;
        int st[3];
        logic done;
        st[0] = c.s0; st[1] = c.s1; st[2] = c.s2;
        i_hop = c.hop_a;
        i_ready = (c.rmode == 2) ? 1'b0 : 1'b1;
        if (rst) do_reset();
        exp_q.delete();
        for (int f = 0; f < c.nframes; f++)
            for (int k = 0; k < N; k++) exp_q.push_back(DW'(base + st[f] + k));
        mon_beat = 0; frames_done = 0; first_seen = 0; stall_pend = 0;
        mon_en = 1;
        idx = 0;
        done = 0;
        for (int t = 0; t < 600; t++) begin
            if (idx >= c.nsamp && exp_q.size() == 0) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            if (idx < c.nsamp) begin
                i_valid = 1;
                i_data  = DW'(base + idx);
                if (idx == 7) wr7_cyc = cyc + 1;
                idx++;
            end else begin
                i_valid = 0;
            end
            case (c.rmode)
                1: i_ready = ((t % 4) == 0) || ((t % 4) == 3);
                2: i_ready = (idx >= c.nsamp);
                default: i_ready = 1;
            endcase
            if (first_seen) i_hop = c.hop_b;
        end
        check({tag, "_drained"}, int'(done), 1);
        @(posedge clk); #1;
        i_valid = 0;
        i_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_frames"}, int'(o_frame_count), c.nframes);
        check({tag, "_overflow"}, int'(o_overflow), c.ovf);
        check({tag, "_idle_valid"}, int'(o_valid), 0);
        check({tag, "_latency"}, first_cyc - wr7_cyc, 2);
        i_clear_overflow = 1;
        @(posedge clk); #1;
        i_clear_overflow = 0;
        check({tag, "_ovf_clear"}, int'(o_overflow), 0);
        mon_en = 0;
    endtask

    initial begin
        logic hit;
        cases[0] = '{4'd4, 4'd4, 16, 0, 3, 0, 4, 8, 0};
        cases[1] = '{4'd8, 4'd8, 16, 0, 2, 0, 8, 0, 0};
        cases[2] = '{4'd0, 4'd0, 16, 0, 2, 0, 8, 0, 0};
        cases[3] = '{4'd9, 4'd9, 16, 0, 2, 0, 8, 0, 0};
        cases[4] = '{4'd2, 4'd2, 10, 1, 2, 0, 2, 0, 0};
        cases[5] = '{4'd4, 4'd4, 17, 2, 3, 0, 4, 8, 1};
        cases[6] = '{4'd4, 4'd2, 14, 0, 3, 0, 4, 6, 0};

        // Reset state
        i_resetn = 0;
        #12;
        check("rst_valid", int'(o_valid), 0);
        check("rst_last", int'(o_last), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_frames", int'(o_frame_count), 0);
        check("rst_overflow", int'(o_overflow), 0);

        for (int i = 0; i < 7; i++)
            run_case(cases[i], 0, 1'b1, $sformatf("case%0d", i));

        // Reset asserted while beat 3 of frame0 is presented
        i_hop = 4'd4;
        i_ready = 1;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(DW'(k));
        mon_beat = 0; frames_done = 0; first_seen = 0; stall_pend = 0;
        mon_en = 1;
        hit = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            i_valid = (t < N);
            i_data  = DW'(t);
            if (mon_beat == 3 && exp_q.size() == 5) begin
                hit = 1;
                break;
            end
        end
        check("midrst_reached_beat3", int'(hit), 1);
        check("midrst_valid_before", int'(o_valid), 1);
        mon_en = 0;
        i_resetn = 0;
        i_valid = 0;
        #1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_last", int'(o_last), 0);
        check("midrst_frames", int'(o_frame_count), 0);
        repeat (2) @(posedge clk);
        #1 i_resetn = 1;
        run_case('{4'd4, 4'd4, 8, 0, 1, 0, 0, 0, 0}, 100, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
